rob_core: RTL and testbench

//  Dual-allocate, dual-commit reorder buffer sitting directly downstream of rob_receiver.
//  - Takes up to two registered decoded instructions per cycle and allocates circular-buffer entries in program order.
//  - Returns a tag per allocated entry; marks entries complete on execution writeback.
//  - Retires up to two completed entries per cycle, strictly in order.
//  - Raises a precise exception or accepts an external flush.

---
 rtl/rob_core_if.sv | 56 +++++
 rtl/rob_core.sv | 186 ++++++++++++++++++
 tb/tb_rob_core.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_core_if.sv
// Bundle of the allocate, writeback, flush, commit and exception signals
// exchanged between the decode front end and the reorder buffer.
interface rob_core_if #(
    parameter int INS  = 32,
    parameter int XLEN = 32,
    parameter int AW   = 4
);
    // allocation side
    logic            ins1_valid;
    logic [INS-1:0]  ins1;
    logic [INS-1:0]  pc1;
    logic            ins2_valid;
    logic [INS-1:0]  ins2;
    logic [INS-1:0]  pc2;
    logic            alloc_ready;
    logic [AW-1:0]   tag1;
    logic [AW-1:0]   tag2;
    // writeback / control
    logic            wb_valid;
    logic [AW-1:0]   wb_tag;
    logic [XLEN-1:0] wb_result;
    logic            wb_exc;
    logic            flush;
    // commit / exception
    logic            cm1_valid;
    logic [INS-1:0]  cm1_pc;
    logic [INS-1:0]  cm1_ins;
    logic [XLEN-1:0] cm1_result;
    logic            cm2_valid;
    logic [INS-1:0]  cm2_pc;
    logic [INS-1:0]  cm2_ins;
    logic [XLEN-1:0] cm2_result;
    logic            exc_valid;
    logic [INS-1:0]  exc_pc;
    logic [AW:0]     count;

    // Driver of instructions, writebacks and flush; consumer of commits.
    modport master (
        output ins1_valid, ins1, pc1, ins2_valid, ins2, pc2,
        output wb_valid, wb_tag, wb_result, wb_exc, flush,
        input  alloc_ready, tag1, tag2,
        input  cm1_valid, cm1_pc, cm1_ins, cm1_result,
        input  cm2_valid, cm2_pc, cm2_ins, cm2_result,
        input  exc_valid, exc_pc, count
    );

    // The reorder buffer itself.
    modport slave (
        input  ins1_valid, ins1, pc1, ins2_valid, ins2, pc2,
        input  wb_valid, wb_tag, wb_result, wb_exc, flush,
        output alloc_ready, tag1, tag2,
        output cm1_valid, cm1_pc, cm1_ins, cm1_result,
        output cm2_valid, cm2_pc, cm2_ins, cm2_result,
        output exc_valid, exc_pc, count
    );
endinterface

// File: rtl/rob_core.sv
// Dual-allocate / dual-commit reorder buffer. Entries live in a circular
// buffer addressed by head (oldest) and tail (next free); count tells full
// from empty. Commit and exception decisions are taken from registered
// state only, and their outputs are registered.
module rob_core #(
    parameter  int INS   = 32,
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    rob_core_if.slave  bus
);
    typedef logic [AW-1:0] ptr_t;

    localparam logic [AW:0] ALLOC_LIMIT = (AW+1)'(DEPTH - 2);

    // pointers and per-entry status bits
    ptr_t             head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] exc_q, exc_d;

    // entry payload; never needs reset because valid qualifies it
    logic [INS-1:0]   pc_mem  [DEPTH];
    logic [INS-1:0]   ins_mem [DEPTH];
    logic [XLEN-1:0]  res_mem [DEPTH];

    // registered commit / exception outputs
    logic             cm1_valid_q, cm1_valid_d, cm2_valid_q, cm2_valid_d;
    logic [INS-1:0]   cm1_pc_q, cm1_pc_d, cm1_ins_q, cm1_ins_d;
    logic [INS-1:0]   cm2_pc_q, cm2_pc_d, cm2_ins_q, cm2_ins_d;
    logic [XLEN-1:0]  cm1_res_q, cm1_res_d, cm2_res_q, cm2_res_d;
    logic             exc_valid_q, exc_valid_d;
    logic [INS-1:0]   exc_pc_q, exc_pc_d;

    logic             alloc_ready;
    ptr_t             head1, tail1, wr2_idx;
    logic             wr1_en, wr2_en, wb_en;
    logic             c1, c2, exc_fire;
    logic [1:0]       n_alloc, n_commit;

    assign head1 = head_q + ptr_t'(1);
    assign tail1 = tail_q + ptr_t'(1);

    // Allocation / writeback / commit decode from current registered state.
    always_comb begin
        alloc_ready = (count_q <= ALLOC_LIMIT);
        wr1_en      = alloc_ready & bus.ins1_valid;
        wr2_en      = alloc_ready & bus.ins2_valid;
        // a lone slot-2 instruction takes the tail slot itself
        wr2_idx     = bus.ins1_valid ? tail1 : tail_q;
        n_alloc     = {1'b0, wr1_en} + {1'b0, wr2_en};
        wb_en       = bus.wb_valid & valid_q[bus.wb_tag];
        c1          = valid_q[head_q] & done_q[head_q] & ~exc_q[head_q];
        c2          = c1 & valid_q[head1] & done_q[head1] & ~exc_q[head1];
        exc_fire    = valid_q[head_q] & done_q[head_q] & exc_q[head_q];
        n_commit    = {1'b0, c1} + {1'b0, c2};
    end

    // Next-state for pointers, count and status bits; flush or a firing
    // exception squashes everything including same-cycle traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        if (bus.flush || exc_fire) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
        end else begin
            if (c1) valid_d[head_q] = 1'b0;
            if (c2) valid_d[head1]  = 1'b0;
            if (wb_en) begin
                done_d[bus.wb_tag] = 1'b1;
                exc_d[bus.wb_tag]  = bus.wb_exc;
            end
            // allocated slots are free slots, so they never collide with
            // the entries retiring this cycle
            if (wr1_en) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                exc_d[tail_q]   = 1'b0;
            end
            if (wr2_en) begin
                valid_d[wr2_idx] = 1'b1;
                done_d[wr2_idx]  = 1'b0;
                exc_d[wr2_idx]   = 1'b0;
            end
            head_d  = head_q + ptr_t'(n_commit);
            tail_d  = tail_q + ptr_t'(n_alloc);
            count_d = count_q + (AW+1)'(n_alloc) - (AW+1)'(n_commit);
        end
    end

    // Next values of the registered commit and exception outputs.
    always_comb begin
        cm1_valid_d = c1 & ~bus.flush;
        cm2_valid_d = c2 & ~bus.flush;
        exc_valid_d = exc_fire & ~bus.flush;
        cm1_pc_d    = pc_mem[head_q];
        cm1_ins_d   = ins_mem[head_q];
        cm1_res_d   = res_mem[head_q];
        cm2_pc_d    = pc_mem[head1];
        cm2_ins_d   = ins_mem[head1];
        cm2_res_d   = res_mem[head1];
        exc_pc_d    = pc_mem[head_q];
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            exc_q       <= '0;
            cm1_valid_q <= 1'b0;
            cm2_valid_q <= 1'b0;
            cm1_pc_q    <= '0;
            cm1_ins_q   <= '0;
            cm1_res_q   <= '0;
            cm2_pc_q    <= '0;
            cm2_ins_q   <= '0;
            cm2_res_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            cm1_valid_q <= cm1_valid_d;
            cm2_valid_q <= cm2_valid_d;
            cm1_pc_q    <= cm1_pc_d;
            cm1_ins_q   <= cm1_ins_d;
            cm1_res_q   <= cm1_res_d;
            cm2_pc_q    <= cm2_pc_d;
            cm2_ins_q   <= cm2_ins_d;
            cm2_res_q   <= cm2_res_d;
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
        end
    end

    // Payload writes for new entries and writeback results.
    always_ff @(posedge clk) begin
        if (wr1_en) begin
            pc_mem[tail_q]  <= bus.pc1;
            ins_mem[tail_q] <= bus.ins1;
        end
        if (wr2_en) begin
            pc_mem[wr2_idx]  <= bus.pc2;
            ins_mem[wr2_idx] <= bus.ins2;
        end
        if (wb_en) begin
            res_mem[bus.wb_tag] <= bus.wb_result;
        end
    end

    assign bus.alloc_ready = alloc_ready;
    assign bus.tag1        = tail_q;
    assign bus.tag2        = tail1;
    assign bus.count       = count_q;
    assign bus.cm1_valid   = cm1_valid_q;
    assign bus.cm1_pc      = cm1_pc_q;
    assign bus.cm1_ins     = cm1_ins_q;
    assign bus.cm1_result  = cm1_res_q;
    assign bus.cm2_valid   = cm2_valid_q;
    assign bus.cm2_pc      = cm2_pc_q;
    assign bus.cm2_ins     = cm2_ins_q;
    assign bus.cm2_result  = cm2_res_q;
    assign bus.exc_valid   = exc_valid_q;
    assign bus.exc_pc      = exc_pc_q;
endmodule

// File: tb/tb_rob_core.sv
// Bench for rob_core: a queue-based in-order model predicts every output
// each cycle, and directed scenarios add hand-computed literal checks.
module tb_rob_core;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_commits = 0;

    rob_core_if #(.INS(32), .XLEN(32), .AW(4)) bus ();

    rob_core #(.INS(32), .XLEN(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model: in-order queue of live entries ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] res;
        bit          done;
        bit          exc;
    } ent_t;

    ent_t        mq[$];
    int          m_tail = 0;
    logic        e_cm1_v = 0, e_cm2_v = 0, e_exc_v = 0;
    logic [31:0] e_cm1_pc = 0, e_cm1_ins = 0, e_cm1_res = 0;
    logic [31:0] e_cm2_pc = 0, e_cm2_ins = 0, e_cm2_res = 0;
    logic [31:0] e_exc_pc = 0;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk or posedge rst) begin
        int   n, head, widx, ncm, nal;
        bit   c1, c2, ex, ok;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_tail  = 0;
            e_cm1_v = 0;
            e_cm2_v = 0;
            e_exc_v = 0;
        end else begin
            n   = mq.size();
            c1  = (n >= 1) && mq[0].done && !mq[0].exc;
            c2  = c1 && (n >= 2) && mq[1].done && !mq[1].exc;
            ex  = (n >= 1) && mq[0].done && mq[0].exc;
            ok  = (n <= DEPTH - 2);
            head = ((m_tail - n) % DEPTH + DEPTH) % DEPTH;
            e_cm1_v = 0;
            e_cm2_v = 0;
            e_exc_v = 0;
            if (bus.flush) begin
                mq.delete();
                m_tail = 0;
            end else if (ex) begin
                e_exc_v  = 1;
                e_exc_pc = mq[0].pc;
                mq.delete();
                m_tail = 0;
            end else begin
                if (c1) begin
                    e_cm1_v = 1; e_cm1_pc = mq[0].pc; e_cm1_ins = mq[0].ins; e_cm1_res = mq[0].res;
                end
                if (c2) begin
                    e_cm2_v = 1; e_cm2_pc = mq[1].pc; e_cm2_ins = mq[1].ins; e_cm2_res = mq[1].res;
                end
                if (bus.wb_valid) begin
                    widx = (int'(bus.wb_tag) - head + DEPTH) % DEPTH;
                    if (widx < n) begin
                        e = mq[widx];
                        e.done = 1;
                        e.exc  = bus.wb_exc;
                        e.res  = bus.wb_result;
                        mq[widx] = e;
                    end
                end
                ncm = int'(c1) + int'(c2);
                repeat (ncm) void'(mq.pop_front());
                nal = 0;
                if (ok && bus.ins1_valid) begin
                    e = '{pc: bus.pc1, ins: bus.ins1, res: 32'h0, done: 0, exc: 0};
                    mq.push_back(e);
                    nal++;
                end
                if (ok && bus.ins2_valid) begin
                    e = '{pc: bus.pc2, ins: bus.ins2, res: 32'h0, done: 0, exc: 0};
                    mq.push_back(e);
                    nal++;
                end
                m_tail = (m_tail + nal) % DEPTH;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("alloc_ready", 64'(bus.alloc_ready), 64'(mq.size() <= DEPTH - 2));
            chk("tag1", 64'(bus.tag1), 64'(m_tail));
            chk("tag2", 64'(bus.tag2), 64'((m_tail + 1) % DEPTH));
            chk("count", 64'(bus.count), 64'(mq.size()));
            chk("cm1_valid", 64'(bus.cm1_valid), 64'(e_cm1_v));
            chk("cm2_valid", 64'(bus.cm2_valid), 64'(e_cm2_v));
            chk("exc_valid", 64'(bus.exc_valid), 64'(e_exc_v));
            if (e_cm1_v) begin
                chk("cm1_pc", 64'(bus.cm1_pc), 64'(e_cm1_pc));
                chk("cm1_ins", 64'(bus.cm1_ins), 64'(e_cm1_ins));
                chk("cm1_result", 64'(bus.cm1_result), 64'(e_cm1_res));
            end
            if (e_cm2_v) begin
                chk("cm2_pc", 64'(bus.cm2_pc), 64'(e_cm2_pc));
                chk("cm2_ins", 64'(bus.cm2_ins), 64'(e_cm2_ins));
                chk("cm2_result", 64'(bus.cm2_result), 64'(e_cm2_res));
            end
            if (e_exc_v) chk("exc_pc", 64'(bus.exc_pc), 64'(e_exc_pc));
            n_commits += int'(bus.cm1_valid) + int'(bus.cm2_valid);
            $display("cyc t=%0t cnt=%0d rdy=%0b tag1=%0d cm1=%0b/%h cm2=%0b/%h exc=%0b/%h",
                     $time, bus.count, bus.alloc_ready, bus.tag1, bus.cm1_valid, bus.cm1_pc,
                     bus.cm2_valid, bus.cm2_pc, bus.exc_valid, bus.exc_pc);
        end
    end

    // ---------------- stimulus ----------------
    // Present one cycle of inputs, then wait for the next falling edge.
    task automatic cyc(input bit v1, input logic [31:0] p1, input bit v2, input logic [31:0] p2,
                       input bit wbv, input int wbt, input logic [31:0] wbr, input bit wbe,
                       input bit fl);
        bus.ins1_valid = v1;  bus.pc1 = p1;  bus.ins1 = ins_of(p1);
        bus.ins2_valid = v2;  bus.pc2 = p2;  bus.ins2 = ins_of(p2);
        bus.wb_valid   = wbv; bus.wb_tag = 4'(wbt); bus.wb_result = wbr; bus.wb_exc = wbe;
        bus.flush      = fl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int start, base;
        bus.ins1_valid = 0; bus.ins1 = 0; bus.pc1 = 0;
        bus.ins2_valid = 0; bus.ins2 = 0; bus.pc2 = 0;
        bus.wb_valid = 0; bus.wb_tag = 0; bus.wb_result = 0; bus.wb_exc = 0;
        bus.flush = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_ready", 64'(bus.alloc_ready), 64'd1);
        chk("reset_cm1", 64'(bus.cm1_valid), 64'd0);

        // dual alloc, out-of-order writeback, dual commit
        cyc(1, 32'h100, 1, 32'h104, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h11, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h22, 0, 0);
        idle(1);
        chk("dual_cm1_valid", 64'(bus.cm1_valid), 64'd1);
        chk("dual_cm2_valid", 64'(bus.cm2_valid), 64'd1);
        chk("dual_cm1_pc", 64'(bus.cm1_pc), 64'h100);
        chk("dual_cm2_pc", 64'(bus.cm2_pc), 64'h104);
        chk("dual_cm1_res", 64'(bus.cm1_result), 64'h22);
        chk("dual_cm2_res", 64'(bus.cm2_result), 64'h11);
        idle(1);
        chk("dual_once", 64'(bus.cm1_valid), 64'd0);

        // fill: head/tail at 2
        for (int k = 0; k < 7; k++)
            cyc(1, 32'h1000 + 32'(8 * k), 1, 32'h1004 + 32'(8 * k), 0, 0, 0, 0, 0);
        chk("fill14_ready", 64'(bus.alloc_ready), 64'd1);
        chk("fill14_tag1", 64'(bus.tag1), 64'd0);
        cyc(1, 32'h1038, 0, 0, 0, 0, 0, 0, 0);
        chk("fill15_count", 64'(bus.count), 64'd15);
        chk("fill15_ready", 64'(bus.alloc_ready), 64'd0);
        cyc(1, 32'h2000, 1, 32'h2004, 0, 0, 0, 0, 0);
        chk("ignored_count", 64'(bus.count), 64'd15);
        cyc(0, 0, 0, 0, 1, 2, 32'h1, 0, 0);
        chk("wb_full_ready", 64'(bus.alloc_ready), 64'd0);
        idle(1);
        chk("freed_count", 64'(bus.count), 64'd14);
        chk("freed_ready", 64'(bus.alloc_ready), 64'd1);
        cyc(1, 32'h103C, 1, 32'h1040, 0, 0, 0, 0, 0);
        chk("full_count", 64'(bus.count), 64'd16);
        chk("full_ready", 64'(bus.alloc_ready), 64'd0);
        for (int k = 0; k < 16; k++)
            cyc(0, 0, 0, 0, 1, (3 + k) % DEPTH, 32'h5000 + 32'(k), 0, 0);
        idle(3);
        chk("drain_count", 64'(bus.count), 64'd0);

        // wrap: one allocation and one writeback per cycle
        start = m_tail;
        base  = n_commits;
        for (int i = 0; i < 40; i++)
            cyc(1, 32'h3000 + 32'(4 * i), 0, 0, i > 0, (start + i - 1) % DEPTH,
                32'h7000 + 32'(i), 0, 0);
        cyc(0, 0, 0, 0, 1, (start + 39) % DEPTH, 32'h7777, 0, 0);
        idle(3);
        chk("wrap_commits", 64'(n_commits - base), 64'd40);
        chk("wrap_count", 64'(bus.count), 64'd0);

        // precise exception on the second of three entries
        start = m_tail;
        cyc(1, 32'h204, 1, 32'h208, 0, 0, 0, 0, 0);
        cyc(1, 32'h20C, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, (start + 1) % DEPTH, 32'h0, 1, 0);
        cyc(0, 0, 0, 0, 1, start, 32'h55, 0, 0);
        idle(1);
        chk("exc_pre_cm1", 64'(bus.cm1_valid), 64'd1);
        chk("exc_pre_pc", 64'(bus.cm1_pc), 64'h204);
        chk("exc_pre_cm2", 64'(bus.cm2_valid), 64'd0);
        chk("exc_pre_exc", 64'(bus.exc_valid), 64'd0);
        idle(1);
        chk("exc_valid", 64'(bus.exc_valid), 64'd1);
        chk("exc_pc_lit", 64'(bus.exc_pc), 64'h208);
        chk("exc_count", 64'(bus.count), 64'd0);
        chk("exc_cm1", 64'(bus.cm1_valid), 64'd0);

        // flush with five live entries plus same-cycle alloc and writeback
        cyc(1, 32'h300, 1, 32'h304, 0, 0, 0, 0, 0);
        cyc(1, 32'h308, 1, 32'h30C, 0, 0, 0, 0, 0);
        cyc(1, 32'h310, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h99, 0, 0);
        chk("preflush_count", 64'(bus.count), 64'd5);
        cyc(1, 32'h400, 1, 32'h404, 1, 1, 32'h98, 0, 1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_cm1", 64'(bus.cm1_valid), 64'd0);
        chk("flush_tag1", 64'(bus.tag1), 64'd0);
        idle(1);
        chk("postflush_count", 64'(bus.count), 64'd0);

        // asynchronous reset in the middle of a commit
        cyc(1, 32'h500, 1, 32'h504, 0, 0, 0, 0, 0);
        cyc(1, 32'h508, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h2, 0, 0);
        idle(1);
        chk("prerst_cm1", 64'(bus.cm1_valid), 64'd1);
        chk("prerst_count", 64'(bus.count), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst_cm1", 64'(bus.cm1_valid), 64'd0);
        chk("rst_cm2", 64'(bus.cm2_valid), 64'd0);
        chk("rst_exc", 64'(bus.exc_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        chk("postrst_tag1", 64'(bus.tag1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
